// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator at the head of the fetch stage
//
// Holds the fetch address and advances it under a valid/ready handshake with
// fetch. Trap and branch redirects are applied regardless of the handshake.
// Predecoded call/return hints are applied only when fetch accepts pc_o.
// All outputs are registered except pc_plus4_o.
//
// Optional feature macro: PC_GEN_RAS_EN adds a circular return-address stack.
// When the macro is undefined, a return hint is treated as sequential.
//
// Parameters:
//   X_LEN     address width in bits (>= 8)
//   RESET_VEC PC value after reset (word aligned)
//   RAS_DEPTH return-address-stack entries (power of two, >= 2)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   fetch_ready_i  fetch accepts pc_o this cycle
//   trap_i         trap taken, load trap_vec_i (highest priority)
//   trap_vec_i     trap target
//   redirect_i     mispredict resolved in EX, load redirect_pc_i
//   redirect_pc_i  correct target
//   pred_call_i    instruction at pc_o is a direct call
//   pred_ret_i     instruction at pc_o is a return
//   pred_target_i  direct call target
//   pc_o           current fetch address
//   pc_valid_o     pc_o is valid for fetch
//   pc_plus4_o     pc_o + 4, combinational
module pc_gen #(
  parameter int unsigned       X_LEN     = 32,
  parameter logic [X_LEN-1:0]  RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             fetch_ready_i,
  input  logic             trap_i,
  input  logic [X_LEN-1:0] trap_vec_i,
  input  logic             redirect_i,
  input  logic [X_LEN-1:0] redirect_pc_i,
  input  logic             pred_call_i,
  input  logic             pred_ret_i,
  input  logic [X_LEN-1:0] pred_target_i,
  output logic [X_LEN-1:0] pc_o,
  output logic             pc_valid_o,
  output logic [X_LEN-1:0] pc_plus4_o
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [X_LEN-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             fire;
  logic [X_LEN-1:0] seq_pc;

  // Targets lose their low two bits; misalignment is reported elsewhere.
  function automatic logic [X_LEN-1:0] align(input logic [X_LEN-1:0] a);
    return {a[X_LEN-1:2], 2'b00};
  endfunction

  // Keeps RAS_DEPTH referenced in builds without the stack.
  if (RAS_DEPTH < 2) begin : g_ras_depth_too_small
  end

  assign pc_plus4_o = pc_q + X_LEN'(4);
  assign seq_pc     = align(pc_plus4_o);
  assign fire       = pc_valid_q & fetch_ready_i;
  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [X_LEN-1:0] ras_q [RAS_DEPTH];
  logic [X_LEN-1:0] ras_d [RAS_DEPTH];
  // ras_ptr points at the next free slot; the top entry is one below it.
  // Pushing onto a full stack simply overwrites the oldest slot.
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0] ras_top;

  assign ras_top = ras_ptr_q - PTR_W'(1);
`endif

  always_comb begin
    pc_d       = pc_q;
    state_d    = ST_RUN;
    pc_valid_d = 1'b1;
`ifdef PC_GEN_RAS_EN
    ras_d      = ras_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
`endif
    if (trap_i) begin
      pc_d = align(trap_vec_i);
`ifdef PC_GEN_RAS_EN
      ras_cnt_d = '0;
`endif
    end else if (redirect_i) begin
      pc_d = align(redirect_pc_i);
    end else if (fire && pred_call_i) begin
      pc_d = align(pred_target_i);
`ifdef PC_GEN_RAS_EN
      ras_d[ras_ptr_q] = pc_plus4_o;
      ras_ptr_d        = ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
`endif
    end else if (fire && pred_ret_i) begin
`ifdef PC_GEN_RAS_EN
      if (ras_cnt_q != '0) begin
        pc_d      = align(ras_q[ras_top]);
        ras_ptr_d = ras_top;
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end else begin
        pc_d = seq_pc;
      end
`else
      pc_d = seq_pc;
`endif
    end else if (fire) begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
`ifdef PC_GEN_RAS_EN
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d && (state_d == ST_RUN);
`ifdef PC_GEN_RAS_EN
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      ras_q      <= ras_d;
`endif
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined core; it replaces the plain PC register at the head of the fetch stage. It holds the current fetch address, advances it under a valid/ready handshake with fetch, and applies trap and branch redirects. It also applies predecoded call/return hints, with an optional return-address stack. All outputs are registered except `pc_plus4_o`.

## Interface
- `X_LEN`, 32, address width in bits (≥ 8)
- `RESET_VEC`, 0, value loaded into the PC on reset (word-aligned)
- `RAS_DEPTH`, 4, return-address-stack entries (power of two, ≥ 2); only used with `PC_GEN_RAS_EN`
- `clk_i`  in  1  clock, rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `fetch_ready_i`  in  1  fetch accepts `pc_o` this cycle
- `trap_i`  in  1  trap/exception taken; highest priority
- `trap_vec_i`  in  X_LEN  trap target
- `redirect_i`  in  1  branch/jump resolved as mispredicted in EX
- `redirect_pc_i`  in  X_LEN  correct target
- `pred_call_i`  in  1  predecode: instruction at `pc_o` is a direct call
- `pred_ret_i`  in  1  predecode: instruction at `pc_o` is a return
- `pred_target_i`  in  X_LEN  direct call target
- `pc_o`  out  X_LEN  current fetch address
- `pc_valid_o`  out  1  `pc_o` is valid for fetch
- `pc_plus4_o`  out  X_LEN  `pc_o + 4`, combinational

## Operation
- FSM has two states.
  - BOOT: reset state; `pc_valid_o = 0`.
  - RUN: `pc_valid_o = 1`.
  - BOOT → RUN on the first clock edge after reset release. RUN is left only by reset.
- `fire = pc_valid_o & fetch_ready_i`.
- Next-PC priority, evaluated every edge:
  1. `trap_i`: load `trap_vec_i`. Applies in any state and does not need `fire`.
  2. `redirect_i`: load `redirect_pc_i`. Applies in any state and does not need `fire`.
  3. `fire & pred_call_i`: load `pred_target_i`.
  4. `fire & pred_ret_i`: load the predicted return address (see Configuration).
  5. `fire`: load `pc_plus4_o`.
  6. Otherwise hold `pc_o`.
- A trap or redirect taken in BOOT also moves the FSM to RUN.
- Every loaded target has bits [1:0] forced to 0. The alignment exception is raised elsewhere.
- Arithmetic is modulo 2^X_LEN. The PC increment from the all-ones word address wraps to 0.
- `pred_call_i` and `pred_ret_i` both high: the call wins and the return is ignored.
- Hint inputs are ignored unless `fire` is high.
- Reset values: `pc_o = RESET_VEC`, `pc_valid_o = 0`, state BOOT, RAS count 0, RAS entries 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous).

## Timing
- Every PC update lands on the edge after the cause; the new `pc_o` is visible one cycle later.
- Redirect-to-valid-target latency is 1 cycle, with no bubble.
- Handshake rules:
  - While `fetch_ready_i = 0`, `pc_o` is stable unless `trap_i` or `redirect_i` is asserted.
  - `pc_valid_o` never drops once in RUN.
  - Fetch must not rely on `pc_o` in BOOT.
- `pc_plus4_o` follows `pc_o` combinationally, with no register stage.

## Configuration
- Macro: `PC_GEN_RAS_EN`.
- Defined: a circular return-address stack of `RAS_DEPTH` entries and a saturating count is compiled in.
  - On an accepted call, push `pc_plus4_o`.
  - Push when full overwrites the oldest entry; the count stays at `RAS_DEPTH`.
  - On an accepted return with count > 0, next PC = top entry. Pop it.
  - On an accepted return with count = 0, next PC = `pc_plus4_o` and the count stays 0.
  - `trap_i` clears the count to 0. `redirect_i` leaves the stack unchanged; there is no repair.
- Undefined: no stack storage exists. A return hint is treated as sequential (next PC = `pc_plus4_o`). Calls still redirect to `pred_target_i`. `RAS_DEPTH` has no effect.

## Test plan
- Reset and boot: `RESET_VEC = 0x100`, release reset, hold `fetch_ready_i = 1` → cycle 0: `pc_valid_o = 0`, `pc_o = 0x100`; then `pc_o` = 0x100, 0x104, 0x108 on consecutive cycles.
- Stall and priority: `fetch_ready_i = 0` for 3 cycles at `pc_o = 0x200` → `pc_o` holds 0x200. Then in one cycle assert `redirect_i` (`0x400`), `trap_i` (`trap_vec_i = 0x80`) and `pred_call_i` together → next `pc_o = 0x80`.
- Alignment and wrap: redirect to `0x1003` → `pc_o = 0x1000`. Redirect to `0xFFFF_FFFC`, then fire → `pc_o = 0x0`.
- RAS (macro on, depth 4):
  - Call at 0x10 → 0x500; call at 0x500 → 0x900; return at 0x900 → `pc_o = 0x504`; return at 0x504 → `pc_o = 0x14`; third return → `pc_o` = return PC + 4.
- RAS overflow and trap: 5 calls from 0x0, 0x100, 0x200, 0x300, 0x400 → 4 returns yield 0x404, 0x304, 0x204, 0x104, and a 5th return is sequential. A trap after 2 calls clears the stack, so the next return is sequential.
- Macro off: call at 0x10 → `pc_o = pred_target_i`; return hint at 0x500 → `pc_o = 0x504`.
- Async reset mid-run: assert `rst_n_i` between edges at `pc_o = 0x300` → `pc_o = RESET_VEC` and `pc_valid_o = 0` before the next edge.
